// File: rtl/fpcvt_pkg.sv
// Shared constants, stage-2 bundle and sizing helpers for the fpcvt_pipe fixed-to-float converter.
// Define FPCVT_OVF_FLAG_EN to give fpcvt_pipe an extra saturation flag output (ovf).
package fpcvt_pkg;

  localparam int unsigned W_DEF  = 12;
  localparam int unsigned EW_DEF = 3;
  localparam int unsigned MW_DEF = 4;

  // Constants for the default configuration. Parametrised instances derive their own.
  localparam int unsigned EMAX = (2 ** EW_DEF) - 1;
  localparam int unsigned MAGW = W_DEF - 1;

  typedef struct packed {
    logic              valid;
    logic              s;
    logic [EW_DEF-1:0] e_raw;
    logic [MW_DEF-1:0] f_raw;
    logic              rbit;
  } stage2_t;

  function automatic int unsigned emax_of(input int unsigned ew);
    return (2 ** ew) - 1;
  endfunction

  function automatic int unsigned lz_width(input int unsigned magw);
    return $clog2(magw + 1);
  endfunction

endpackage

// File: rtl/fpcvt_lzc.sv
// Combinational leading-zero counter over an unsigned magnitude.
// An all-zero input reports MAGW leading zeros.
module fpcvt_lzc #(
  parameter int unsigned MAGW = 11,
  parameter int unsigned LZW  = $clog2(MAGW + 1)
) (
  input  logic [MAGW-1:0] mag,
  output logic [LZW-1:0]  lz
);

  // Ascending scan: the last hit is the highest set bit.
  always_comb begin
    lz = LZW'(MAGW);
    for (int i = 0; i < MAGW; i++) begin
      if (mag[i]) begin
        lz = LZW'(MAGW - 1 - i);
      end
    end
  end

endmodule

// File: rtl/fpcvt_pipe.sv
// Three-stage valid/ready pipeline converting W-bit two's complement to sign/exponent/mantissa.
// Define FPCVT_OVF_FLAG_EN to add the ovf output flagging saturated results.
module fpcvt_pipe
  import fpcvt_pkg::*;
#(
  parameter int unsigned W  = W_DEF,
  parameter int unsigned EW = EW_DEF,
  parameter int unsigned MW = MW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  d,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          s,
  output logic [EW-1:0] e,
  output logic [MW-1:0] f
`ifdef FPCVT_OVF_FLAG_EN
  ,
  output logic          ovf
`endif
);

  localparam int unsigned Emax = emax_of(EW);
  localparam int unsigned Magw = W - 1;
  localparam int unsigned Lzw  = lz_width(Magw);

  if (W - 1 != MW + Emax) begin : g_param_check
    $error("fpcvt_pipe: W-1 must equal MW + 2**EW - 1");
  end

  typedef struct packed {
    logic          valid;
    logic          s;
    logic [EW-1:0] e_raw;
    logic [MW-1:0] f_raw;
    logic          rbit;
  } s2_t;

  logic adv;

  // Whole pipeline moves in lockstep whenever the output slot is free or being drained.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1: sign and saturated magnitude.
  logic            neg;
  logic            is_min;
  logic [Magw-1:0] mag_c;
  logic            v1_q;
  logic            s1_q;
  logic [Magw-1:0] mag1_q;

  assign neg    = d[W-1];
  assign is_min = neg && (d[W-2:0] == '0);
  assign mag_c  = is_min ? {Magw{1'b1}} :
                  neg    ? (~d[W-2:0] + Magw'(1)) : d[W-2:0];

  // Stage 2: normalise around the leading one.
  logic [Lzw-1:0] lz;
  s2_t            s2_d;
  s2_t            s2_q;

  fpcvt_lzc #(
    .MAGW (Magw),
    .LZW  (Lzw)
  ) u_lzc (
    .mag (mag1_q),
    .lz  (lz)
  );

  always_comb begin
    s2_d       = '0;
    s2_d.valid = v1_q;
    s2_d.s     = s1_q;
    if (lz < Lzw'(Emax)) begin
      s2_d.e_raw = EW'(Lzw'(Emax) - lz);
    end
    s2_d.f_raw = MW'(mag1_q >> s2_d.e_raw);
    // Appending a zero makes the shifted LSB the bit just below f_raw, and 0 when e_raw is 0.
    s2_d.rbit  = 1'({mag1_q, 1'b0} >> s2_d.e_raw);
  end

  // Stage 3: round half up, renormalise on carry, saturate at the top exponent.
  logic [MW:0]   sum_c;
  logic          at_max_c;
  logic [EW-1:0] e3_c;
  logic [MW-1:0] f3_c;

  always_comb begin
    sum_c    = {1'b0, s2_q.f_raw} + {{MW{1'b0}}, s2_q.rbit};
    at_max_c = sum_c[MW] && (&s2_q.e_raw);
    e3_c     = s2_q.e_raw;
    f3_c     = sum_c[MW-1:0];
    if (at_max_c) begin
      e3_c = '1;
      f3_c = '1;
    end else if (sum_c[MW]) begin
      e3_c       = s2_q.e_raw + EW'(1);
      f3_c       = '0;
      f3_c[MW-1] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      s1_q      <= 1'b0;
      mag1_q    <= '0;
      s2_q      <= '0;
      out_valid <= 1'b0;
      s         <= 1'b0;
      e         <= '0;
      f         <= '0;
    end else if (adv) begin
      v1_q      <= in_valid;
      s1_q      <= neg;
      mag1_q    <= mag_c;
      s2_q      <= s2_d;
      out_valid <= s2_q.valid;
      s         <= s2_q.s;
      e         <= e3_c;
      f         <= f3_c;
    end
  end

`ifdef FPCVT_OVF_FLAG_EN
  logic sat1_q;
  logic sat2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sat1_q <= 1'b0;
      sat2_q <= 1'b0;
      ovf    <= 1'b0;
    end else if (adv) begin
      sat1_q <= is_min;
      sat2_q <= sat1_q;
      ovf    <= sat2_q | at_max_c;
    end
  end
`endif

endmodule

// File: tb/tb_fpcvt_pipe.sv
// Self-checking bench for fpcvt_pipe: directed conversions, stalled stream, reset flush, W=20 sweep.
// Build with FPCVT_OVF_FLAG_EN defined to also check the ovf output.
module tb_fpcvt_pipe;

  typedef struct packed {
    logic        ovf;
    logic        s;
    logic [7:0]  e;
    logic [15:0] f;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] d;
  logic        out_valid;
  logic        out_ready;
  logic        s;
  logic [2:0]  e;
  logic [3:0]  f;

  logic        in_valid20;
  logic        in_ready20;
  logic [19:0] d20;
  logic        out_valid20;
  logic        out_ready20;
  logic        s20;
  logic [3:0]  e20;
  logic [3:0]  f20;

`ifdef FPCVT_OVF_FLAG_EN
  logic ovf;
  logic ovf20;
  logic last_ovf;
`endif

  int   checks = 0;
  int   errors = 0;
  res_t q[$];
  res_t q20[$];

  fpcvt_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .e         (e),
    .f         (f)
`ifdef FPCVT_OVF_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  fpcvt_pipe #(
    .W  (20),
    .EW (4),
    .MW (4)
  ) dut20 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid20),
    .in_ready  (in_ready20),
    .d         (d20),
    .out_valid (out_valid20),
    .out_ready (out_ready20),
    .s         (s20),
    .e         (e20),
    .f         (f20)
`ifdef FPCVT_OVF_FLAG_EN
    ,
    .ovf       (ovf20)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: value = f * 2^e with e chosen so f holds the top MW bits, rounded half up.
  function automatic res_t model(input int w, input int ew, input int mw, input logic [31:0] din);
    res_t   r;
    longint one;
    longint v;
    longint mag;
    longint maxmag;
    longint fr;
    int     p;
    int     er;
    int     emax;
    r   = '0;
    one = 1;
    v   = longint'(din) & ((one << w) - 1);
    if (v >= (one << (w - 1))) v = v - (one << w);
    r.s    = (v < 0);
    mag    = (v < 0) ? -v : v;
    maxmag = (one << (w - 1)) - 1;
    if (mag > maxmag) begin
      mag   = maxmag;
      r.ovf = 1'b1;
    end
    if (mag == 0) return r;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    er   = (p >= mw) ? p - mw + 1 : 0;
    fr   = (er == 0) ? mag : ((mag + (one << (er - 1))) >> er);
    emax = (1 << ew) - 1;
    if (fr == (one << mw)) begin
      if (er == emax) begin
        r.e   = 8'(emax);
        r.f   = 16'((one << mw) - 1);
        r.ovf = 1'b1;
      end else begin
        r.e = 8'(er + 1);
        r.f = 16'(one << (mw - 1));
      end
    end else begin
      r.e = 8'(er);
      r.f = 16'(fr);
    end
    return r;
  endfunction

  // One isolated sample: accepted immediately, result exactly three cycles later.
  task automatic single(input string tag, input logic [11:0] dv, input logic [7:0] exp_sef);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    d         = dv;
    #1;
    check({tag, "_accept"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    d        = '0;
    check({tag, "_lat1"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_lat2"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_sef"}, {s, e, f}, exp_sef);
`ifdef FPCVT_OVF_FLAG_EN
    last_ovf = ovf;
`endif
    @(negedge clk);
    check({tag, "_drain"}, out_valid, 0);
  endtask

  localparam int N20 = 3000;

  logic [11:0] vals12 [16];
  logic [19:0] vals20 [N20];

  initial begin
    int sent;
    int got;
    int cyc;
    int stall_cnt;
    logic stalling;

    rst         = 1'b1;
    in_valid    = 1'b0;
    d           = '0;
    out_ready   = 1'b1;
    in_valid20  = 1'b0;
    d20         = '0;
    out_ready20 = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_sef", {s, e, f}, 0);
    check("rst_out_valid20", out_valid20, 0);
`ifdef FPCVT_OVF_FLAG_EN
    check("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    single("zero", 12'd0, 8'b0_000_0000);
    single("one", 12'd1, 8'b0_000_0001);
    single("d42", 12'd42, 8'b0_010_1011);
    single("d125", 12'd125, 8'b0_100_1000);
`ifdef FPCVT_OVF_FLAG_EN
    check("ovf_125", last_ovf, 0);
`endif
    single("d2047", 12'd2047, 8'b0_111_1111);
`ifdef FPCVT_OVF_FLAG_EN
    check("ovf_2047", last_ovf, 1);
`endif
    single("neg1", 12'hFFF, 8'b1_000_0001);
    single("neg34", 12'hFDE, 8'b1_010_1001);
    single("neg2048", 12'h800, 8'b1_111_1111);
`ifdef FPCVT_OVF_FLAG_EN
    check("ovf_neg2048", last_ovf, 1);
`endif

    // Back-to-back stream with a 4-cycle consumer stall in the middle.
    for (int i = 0; i < 16; i++) vals12[i] = 12'($urandom);
    vals12[5] = 12'h800;
    sent      = 0;
    got       = 0;
    cyc       = 0;
    stall_cnt = 0;
    while ((sent < 16 || got < 16) && cyc < 200) begin
      @(negedge clk);
      stalling = (sent >= 8) && (stall_cnt < 4);
      if (stalling) stall_cnt++;
      out_ready = !stalling;
      in_valid  = (sent < 16);
      d         = (sent < 16) ? vals12[sent] : '0;
      #1;
      if (stalling) begin
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          check("stream_spurious", 1, 0);
        end else begin
          check("stream_sef", {s, e, f}, {q[0].s, q[0].e[2:0], q[0].f[3:0]});
`ifdef FPCVT_OVF_FLAG_EN
          check("stream_ovf", ovf, q[0].ovf);
`endif
          if (out_ready) begin
            void'(q.pop_front());
            got++;
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(12, 3, 4, 32'(d)));
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    check("stream_in_time", (cyc < 200), 1);
    check("stream_count", got, 16);
    check("stream_leftover", q.size(), 0);

    // Reset while three samples are in flight and the consumer is stalled.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    d         = 12'h123;
    @(negedge clk);
    d = 12'h456;
    @(negedge clk);
    d = 12'h9AB;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("flush_full_valid", out_valid, 1);
    check("flush_full_in_ready", in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_sef", {s, e, f}, 0);
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("flush_no_ghost", out_valid, 0);
    end
    single("post_rst", 12'd77, 8'b0_011_1010);

    // W=20 configuration: boundaries, every small value, then random, with random backpressure.
    vals20[0] = 20'h7FFFF;
    vals20[1] = 20'h80000;
    vals20[2] = 20'hFFFFF;
    vals20[3] = 20'h7FFFE;
    vals20[4] = 20'h00010;
    vals20[5] = 20'h0001F;
    vals20[6] = 20'h3FFFF;
    vals20[7] = 20'h40000;
    for (int i = 8; i < N20; i++) begin
      vals20[i] = (i < 1032) ? 20'(i - 8) : 20'($urandom);
    end
    sent = 0;
    got  = 0;
    cyc  = 0;
    while ((sent < N20 || got < N20) && cyc < 20000) begin
      @(negedge clk);
      out_ready20 = ($urandom_range(3) != 0);
      in_valid20  = (sent < N20);
      d20         = (sent < N20) ? vals20[sent] : '0;
      #1;
      if (out_valid20) begin
        if (q20.size() == 0) begin
          check("w20_spurious", 1, 0);
        end else begin
          check("w20_sef", {s20, e20, f20}, {q20[0].s, q20[0].e[3:0], q20[0].f[3:0]});
`ifdef FPCVT_OVF_FLAG_EN
          check("w20_ovf", ovf20, q20[0].ovf);
`endif
          if (out_ready20) begin
            void'(q20.pop_front());
            got++;
          end
        end
      end
      if (in_valid20 && in_ready20) begin
        q20.push_back(model(20, 4, 4, 32'(d20)));
        sent++;
      end
      cyc++;
    end
    in_valid20 = 1'b0;
    check("w20_in_time", (cyc < 20000), 1);
    check("w20_count", got, N20);

    @(negedge clk);
    out_ready20 = 1'b1;
    in_valid20  = 1'b1;
    d20         = 20'h7FFFF;
    #1;
    check("w20_max_accept", in_ready20, 1);
    @(negedge clk);
    in_valid20 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("w20_max_valid", out_valid20, 1);
    check("w20_max_sef", {s20, e20, f20}, 9'b0_1111_1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
